prog_loader: RTL

Byte-stream program loader that writes the 64×16 instruction memory that the fetch stage reads, while holding the pipeline stopped. It accepts a length-prefixed byte stream over a valid/ready handshake and packs byte pairs into 16-bit instructions. It writes them to consecutive instruction addresses from 0. When loading completes, it releases the processor with a one-cycle restart pulse.

---
 rtl/prog_loader_pkg.sv | 27 ++
 rtl/prog_loader_if.sv | 32 +++
 rtl/loader_timeout.sv | 30 +++
 rtl/prog_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared sizes, state encoding and helpers for the program loader.
package prog_loader_pkg;

    localparam int unsigned DEPTH          = 64;
    localparam int unsigned ADDR_W         = $clog2(DEPTH);
    localparam int unsigned CNT_W          = $clog2(DEPTH + 1);
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 16;
    localparam int unsigned TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WR,
        CSUM,
        FIN,
        ERR
    } state_t;

    // States in which a stream byte may be accepted (and the gap timer runs).
    function automatic logic is_rx_state(input state_t s);
        return (s == LEN) || (s == HI) || (s == LO) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // Environment side: produces the stream, observes the memory writes.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte gap counter; expire_c flags the last allowed idle cycle.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire_c = en && (cnt == LAST);

    // Count idle cycles while enabled; any accepted byte or leaving the timed states restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!expire_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed byte stream into instruction memory while
// holding the CPU, then releases it with a one-cycle restart pulse.
// Optional: define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte
// making the modulo-256 sum of the whole stream zero.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    prog_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             cpu_restart,
    output logic             busy,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [BYTE_W-1:0] DEPTH_B = BYTE_W'(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [BYTE_W-1:0] hi_byte;
    logic              byte_acc_c;
    logic              timeout_c;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    assign byte_acc_c = bus.rx_valid && bus.rx_ready;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (byte_acc_c),
        .en       (is_rx_state(state)),
        .expire_c (timeout_c)
    );

    // Load sequencer: state plus every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b0;
            cpu_restart    <= 1'b0;
            busy           <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            words_loaded   <= '0;
            n_words        <= '0;
            word_idx       <= '0;
            hi_byte        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            cpu_restart <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (byte_acc_c) begin
                csum <= csum + bus.rx_data;
            end
`endif
            case (state)
                IDLE, ERR: begin
                    if (load_start) begin
                        state        <= LEN;
                        bus.rx_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        word_idx     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                end
                LEN: begin
                    if (byte_acc_c && (bus.rx_data != '0) && (bus.rx_data <= DEPTH_B)) begin
                        n_words <= CNT_W'(bus.rx_data);
                        state   <= HI;
                    end else if (byte_acc_c || timeout_c) begin
                        state        <= ERR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        load_err     <= 1'b1;
                    end
                end
                HI: begin
                    if (byte_acc_c) begin
                        hi_byte <= bus.rx_data;
                        state   <= LO;
                    end else if (timeout_c) begin
                        state        <= ERR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        load_err     <= 1'b1;
                    end
                end
                LO: begin
                    if (byte_acc_c) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= word_idx;
                        bus.imem_wdata <= {hi_byte, bus.rx_data};
                        bus.rx_ready   <= 1'b0;
                        state          <= WR;
                    end else if (timeout_c) begin
                        state        <= ERR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        load_err     <= 1'b1;
                    end
                end
                WR: begin
                    words_loaded <= words_loaded + CNT_W'(1);
                    if (CNT_W'(word_idx) + CNT_W'(1) == n_words) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state        <= CSUM;
                        bus.rx_ready <= 1'b1;
`else
                        state        <= FIN;
                        cpu_restart  <= 1'b1;
                        cpu_hold     <= 1'b0;
                        busy         <= 1'b0;
                        load_done    <= 1'b1;
`endif
                    end else begin
                        word_idx     <= word_idx + ADDR_W'(1);
                        state        <= HI;
                        bus.rx_ready <= 1'b1;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (byte_acc_c && (BYTE_W'(csum + bus.rx_data) == '0)) begin
                        state        <= FIN;
                        bus.rx_ready <= 1'b0;
                        cpu_restart  <= 1'b1;
                        cpu_hold     <= 1'b0;
                        busy         <= 1'b0;
                        load_done    <= 1'b1;
                    end else if (byte_acc_c || timeout_c) begin
                        state        <= ERR;
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        load_err     <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    bus.rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
